frv_gpr_writeback: RTL and testbench

Write-side sequencer for the general purpose register file. It merges results from the in-order pipeline with results from a long-latency unit (mul/div, loads) and drives the register file destination write port. The long-latency results go through a small queue. The block suppresses writes to x0 and can optionally split 64-bit wide writes into two narrow writes. It sits between the writeback stage and the GPR write port, and publishes a pending-write mask to the hazard logic.

---
 rtl/frv_gpr_writeback.sv | 152 +++++++++++++++
 tb/tb_frv_gpr_writeback.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/frv_gpr_writeback.sv
// frv_gpr_writeback: merges pipeline and long-latency results onto the GPR write port
module frv_gpr_writeback #(
    parameter int DEPTH      = 2,
    parameter bit SPLIT_WIDE = 0
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic        a_wide,
    input  logic [31:0] a_wdata,
    input  logic [31:0] a_wdata_hi,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic        b_wide,
    input  logic [31:0] b_wdata,
    input  logic [31:0] b_wdata_hi,
    output logic        rd_wen,
    output logic        rd_wide,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic [31:0] rd_wdata_hi,
    output logic [31:0] pend,
    output logic        err_wide
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t         state, state_n;
    logic [4:0]     f_addr [DEPTH];
    logic           f_wide [DEPTH];
    logic [31:0]    f_lo   [DEPTH];
    logic [31:0]    f_hi   [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic [4:0]     sec_addr;
    logic [31:0]    sec_data;
    logic           full, use_a, pop, push, iss, odd, wide_ok;
    logic [4:0]     r_addr;
    logic           r_wide;
    logic [31:0]    r_lo, r_hi;
    logic           n_wen, n_wide, n_err;
    logic [4:0]     n_addr;
    logic [31:0]    n_lo, n_hi, p;

    // Handshakes and issue selection; a full queue starves channel A to drain B
    always_comb begin
        full    = count == (AW+1)'(DEPTH);
        b_ready = !full;
        a_ready = state == IDLE && !full;
        use_a   = a_valid && a_ready;
        pop     = state == IDLE && !use_a && count != '0;
        push    = b_valid && b_ready;
        iss     = use_a || pop;
        r_addr  = use_a ? a_addr : f_addr[rd_ptr];
        r_wide  = use_a ? a_wide : f_wide[rd_ptr];
        r_lo    = use_a ? a_wdata : f_lo[rd_ptr];
        r_hi    = use_a ? a_wdata_hi : f_hi[rd_ptr];
        odd     = r_wide && r_addr[0];
        wide_ok = r_wide && !r_addr[0];
    end

    // Legalise the issued request and compute the next registered write port values
    always_comb begin
        state_n = state;
        n_wen   = 1'b0;
        n_wide  = 1'b0;
        n_err   = 1'b0;
        n_addr  = rd_addr;
        n_lo    = rd_wdata;
        n_hi    = rd_wdata_hi;
        if (state == SECOND) begin
            n_wen   = 1'b1;
            n_addr  = sec_addr;
            n_lo    = sec_data;
            state_n = IDLE;
        end else if (iss) begin
            n_err  = odd;
            n_addr = r_addr;
            n_lo   = r_lo;
            n_hi   = r_hi;
            if (SPLIT_WIDE && wide_ok) begin
                n_wen = 1'b1;
                if (r_addr == 5'd0) begin
                    n_addr = 5'd1;
                    n_lo   = r_hi;
                end else begin
                    state_n = SECOND;
                end
            end else begin
                n_wen  = wide_ok || r_addr != 5'd0;
                n_wide = wide_ok;
            end
        end
    end

    // Pending mask over live queue entries and a held second half; x0 never pends
    always_comb begin
        p = '0;
        for (int j = 0; j < DEPTH; j++)
            if ({1'b0, AW'(j) - rd_ptr} < count)
                p = p | (32'd1 << f_addr[j]) | (f_wide[j] ? (32'd1 << (f_addr[j] | 5'd1)) : 32'd0);
        if (state == SECOND) p = p | (32'd1 << sec_addr);
        pend = p & ~32'd1;
    end

    // Queue storage needs no reset; liveness comes from count
    always_ff @(posedge g_clk) begin
        if (push) begin
            f_addr[wr_ptr] <= b_addr;
            f_wide[wr_ptr] <= b_wide;
            f_lo[wr_ptr]   <= b_wdata;
            f_hi[wr_ptr]   <= b_wdata_hi;
        end
    end

    // State, queue pointers and registered write port
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            sec_addr    <= '0;
            sec_data    <= '0;
            rd_wen      <= 1'b0;
            rd_wide     <= 1'b0;
            rd_addr     <= '0;
            rd_wdata    <= '0;
            rd_wdata_hi <= '0;
            err_wide    <= 1'b0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr + AW'(push);
            rd_ptr      <= rd_ptr + AW'(pop);
            count       <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (state == IDLE && iss) begin
                sec_addr <= r_addr | 5'd1;
                sec_data <= r_hi;
            end
            rd_wen      <= n_wen;
            rd_wide     <= n_wide;
            rd_addr     <= n_addr;
            rd_wdata    <= n_lo;
            rd_wdata_hi <= n_hi;
            err_wide    <= n_err;
        end
    end
endmodule

// File: tb/tb_frv_gpr_writeback.sv
// tb_frv_gpr_writeback: directed checks of a non-split and a split instance driven in parallel
module tb_frv_gpr_writeback;
    logic        g_clk = 1'b0, g_reset = 1'b0;
    logic        a_valid = 1'b0, a_wide = 1'b0, b_valid = 1'b0, b_wide = 1'b0;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, a_wdata_hi = '0, b_wdata = '0, b_wdata_hi = '0;
    logic        a_ready0, b_ready0, rd_wen0, rd_wide0, err0;
    logic        a_ready1, b_ready1, rd_wen1, rd_wide1, err1;
    logic [4:0]  rd_addr0, rd_addr1;
    logic [31:0] rd_wdata0, rd_wdata_hi0, pend0, rd_wdata1, rd_wdata_hi1, pend1;
    int checks = 0, failures = 0;

    always #5 g_clk = ~g_clk;

    frv_gpr_writeback #(.DEPTH(2), .SPLIT_WIDE(0)) dut0 (
        .g_clk(g_clk), .g_reset(g_reset),
        .a_valid(a_valid), .a_ready(a_ready0), .a_addr(a_addr), .a_wide(a_wide), .a_wdata(a_wdata), .a_wdata_hi(a_wdata_hi),
        .b_valid(b_valid), .b_ready(b_ready0), .b_addr(b_addr), .b_wide(b_wide), .b_wdata(b_wdata), .b_wdata_hi(b_wdata_hi),
        .rd_wen(rd_wen0), .rd_wide(rd_wide0), .rd_addr(rd_addr0), .rd_wdata(rd_wdata0), .rd_wdata_hi(rd_wdata_hi0),
        .pend(pend0), .err_wide(err0));

    frv_gpr_writeback #(.DEPTH(2), .SPLIT_WIDE(1)) dut1 (
        .g_clk(g_clk), .g_reset(g_reset),
        .a_valid(a_valid), .a_ready(a_ready1), .a_addr(a_addr), .a_wide(a_wide), .a_wdata(a_wdata), .a_wdata_hi(a_wdata_hi),
        .b_valid(b_valid), .b_ready(b_ready1), .b_addr(b_addr), .b_wide(b_wide), .b_wdata(b_wdata), .b_wdata_hi(b_wdata_hi),
        .rd_wen(rd_wen1), .rd_wide(rd_wide1), .rd_addr(rd_addr1), .rd_wdata(rd_wdata1), .rd_wdata_hi(rd_wdata_hi1),
        .pend(pend1), .err_wide(err1));

    task automatic tick;
        @(posedge g_clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] ad, input logic w, input logic [31:0] lo, input logic [31:0] hi);
        a_valid = v; a_addr = ad; a_wide = w; a_wdata = lo; a_wdata_hi = hi;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] ad, input logic w, input logic [31:0] lo, input logic [31:0] hi);
        b_valid = v; b_addr = ad; b_wide = w; b_wdata = lo; b_wdata_hi = hi;
    endtask

    task automatic do_reset;
        drive_a(0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0);
        g_reset = 1'b1;
        tick;
        g_reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if ({rd_wen0, rd_wide0, err0} !== 3'b000) begin failures++; $display("FAIL reset_ctl0 got=%b exp=000", {rd_wen0, rd_wide0, err0}); end
        checks++; if ({rd_addr0, rd_wdata0, rd_wdata_hi0} !== 69'd0) begin failures++; $display("FAIL reset_data0 got=%h exp=0", {rd_addr0, rd_wdata0, rd_wdata_hi0}); end
        checks++; if ({rd_wen1, rd_addr1, rd_wdata1, rd_wdata_hi1} !== 70'd0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", {rd_wen1, rd_addr1, rd_wdata1, rd_wdata_hi1}); end
        checks++; if (pend0 !== 32'd0) begin failures++; $display("FAIL reset_pend got=%h exp=0", pend0); end
        checks++; if ({a_ready0, b_ready0} !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", {a_ready0, b_ready0}); end
    endtask

    task automatic test_single_a;
        do_reset;
        drive_a(1, 5, 0, 32'hDEADBEEF, 0);
        checks++; if (a_ready0 !== 1'b1) begin failures++; $display("FAIL single_a_ready got=%b exp=1", a_ready0); end
        tick;
        drive_a(0, 0, 0, 0, 0);
        checks++; if ({rd_wen0, rd_addr0, rd_wdata0} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin failures++; $display("FAIL single_a got=%b/%0d/%h exp=1/5/deadbeef", rd_wen0, rd_addr0, rd_wdata0); end
        tick;
        checks++; if (rd_wen0 !== 1'b0) begin failures++; $display("FAIL single_a_end got=%b exp=0", rd_wen0); end
    endtask

    task automatic test_priority;
        do_reset;
        drive_a(1, 10, 0, 32'hA0, 0); drive_b(1, 3, 0, 32'h33, 0);
        tick;
        checks++; if ({rd_wen0, rd_addr0, rd_wdata0} !== {1'b1, 5'd10, 32'hA0}) begin failures++; $display("FAIL prio_c0 got=%b/%0d/%h exp=1/10/a0", rd_wen0, rd_addr0, rd_wdata0); end
        checks++; if (pend0 !== 32'h8) begin failures++; $display("FAIL prio_pend0 got=%h exp=8", pend0); end
        drive_a(1, 11, 0, 32'hA1, 0); drive_b(1, 4, 0, 32'h44, 0);
        tick;
        checks++; if ({rd_addr0, rd_wdata0} !== {5'd11, 32'hA1}) begin failures++; $display("FAIL prio_c1 got=%0d/%h exp=11/a1", rd_addr0, rd_wdata0); end
        checks++; if ({a_ready0, b_ready0} !== 2'b00) begin failures++; $display("FAIL prio_full_ready got=%b exp=00", {a_ready0, b_ready0}); end
        checks++; if (pend0 !== 32'h18) begin failures++; $display("FAIL prio_pend1 got=%h exp=18", pend0); end
        drive_a(1, 12, 0, 32'hA2, 0); drive_b(0, 0, 0, 0, 0);
        tick;
        checks++; if ({rd_wen0, rd_addr0, rd_wdata0} !== {1'b1, 5'd3, 32'h33}) begin failures++; $display("FAIL prio_guard got=%b/%0d/%h exp=1/3/33", rd_wen0, rd_addr0, rd_wdata0); end
        checks++; if ({a_ready0, pend0} !== {1'b1, 32'h10}) begin failures++; $display("FAIL prio_after_guard got=%b/%h exp=1/10", a_ready0, pend0); end
        tick;
        drive_a(0, 0, 0, 0, 0);
        checks++; if ({rd_wen0, rd_addr0, rd_wdata0, pend0} !== {1'b1, 5'd12, 32'hA2, 32'h10}) begin failures++; $display("FAIL prio_a_resume got=%b/%0d/%h/%h exp=1/12/a2/10", rd_wen0, rd_addr0, rd_wdata0, pend0); end
        tick;
        checks++; if ({rd_wen0, rd_addr0, rd_wdata0, pend0} !== {1'b1, 5'd4, 32'h44, 32'h0}) begin failures++; $display("FAIL prio_drain got=%b/%0d/%h/%h exp=1/4/44/0", rd_wen0, rd_addr0, rd_wdata0, pend0); end
        tick;
        checks++; if ({rd_wen0, a_ready0, b_ready0} !== 3'b011) begin failures++; $display("FAIL prio_idle got=%b exp=011", {rd_wen0, a_ready0, b_ready0}); end
    endtask

    task automatic test_x0_and_b_latency;
        do_reset;
        drive_a(1, 0, 0, 32'h55, 0);
        checks++; if (a_ready0 !== 1'b1) begin failures++; $display("FAIL x0_ready got=%b exp=1", a_ready0); end
        tick;
        drive_a(0, 0, 0, 0, 0); drive_b(1, 0, 0, 32'h66, 0);
        checks++; if (rd_wen0 !== 1'b0) begin failures++; $display("FAIL x0_a_wen got=%b exp=0", rd_wen0); end
        tick;
        drive_b(1, 9, 0, 32'h99, 0);
        checks++; if (pend0 !== 32'h0) begin failures++; $display("FAIL x0_pend got=%h exp=0", pend0); end
        tick;
        drive_b(0, 0, 0, 0, 0);
        checks++; if ({rd_wen0, pend0} !== {1'b0, 32'h200}) begin failures++; $display("FAIL x0_b_wen got=%b/%h exp=0/200", rd_wen0, pend0); end
        tick;
        checks++; if ({rd_wen0, rd_addr0, rd_wdata0, pend0} !== {1'b1, 5'd9, 32'h99, 32'h0}) begin failures++; $display("FAIL b_latency got=%b/%0d/%h/%h exp=1/9/99/0", rd_wen0, rd_addr0, rd_wdata0, pend0); end
    endtask

    task automatic test_wide;
        do_reset;
        drive_a(1, 6, 1, 32'h11, 32'h22);
        tick;
        drive_a(0, 0, 0, 0, 0);
        checks++; if ({rd_wen0, rd_wide0, rd_addr0, rd_wdata0, rd_wdata_hi0, err0} !== {2'b11, 5'd6, 32'h11, 32'h22, 1'b0}) begin failures++; $display("FAIL wide_nosplit got=%b%b/%0d/%h/%h/%b exp=11/6/11/22/0", rd_wen0, rd_wide0, rd_addr0, rd_wdata0, rd_wdata_hi0, err0); end
        checks++; if ({rd_wen1, rd_wide1, rd_addr1, rd_wdata1} !== {2'b10, 5'd6, 32'h11}) begin failures++; $display("FAIL split_lo got=%b%b/%0d/%h exp=10/6/11", rd_wen1, rd_wide1, rd_addr1, rd_wdata1); end
        checks++; if ({a_ready1, pend1} !== {1'b0, 32'h80}) begin failures++; $display("FAIL split_second got=%b/%h exp=0/80", a_ready1, pend1); end
        tick;
        checks++; if ({rd_wen1, rd_wide1, rd_addr1, rd_wdata1} !== {2'b10, 5'd7, 32'h22}) begin failures++; $display("FAIL split_hi got=%b%b/%0d/%h exp=10/7/22", rd_wen1, rd_wide1, rd_addr1, rd_wdata1); end
        checks++; if ({rd_wen0, a_ready1, pend1} !== {2'b01, 32'h0}) begin failures++; $display("FAIL split_done got=%b%b/%h exp=01/0", rd_wen0, a_ready1, pend1); end
        drive_b(1, 8, 1, 32'h1, 32'h2);
        tick;
        drive_b(0, 0, 0, 0, 0);
        checks++; if ({rd_wen1, pend0, pend1} !== {1'b0, 32'h300, 32'h300}) begin failures++; $display("FAIL wide_pend got=%b/%h/%h exp=0/300/300", rd_wen1, pend0, pend1); end
        tick; tick; tick;
        drive_a(1, 0, 1, 32'h33, 32'h44);
        tick;
        drive_a(0, 0, 0, 0, 0);
        checks++; if ({rd_wen1, rd_addr1, rd_wdata1, a_ready1} !== {1'b1, 5'd1, 32'h44, 1'b1}) begin failures++; $display("FAIL split_x0 got=%b/%0d/%h/%b exp=1/1/44/1", rd_wen1, rd_addr1, rd_wdata1, a_ready1); end
        checks++; if ({rd_wen0, rd_wide0, rd_addr0} !== {2'b11, 5'd0}) begin failures++; $display("FAIL nosplit_x0 got=%b%b/%0d exp=11/0", rd_wen0, rd_wide0, rd_addr0); end
        tick;
        checks++; if (rd_wen1 !== 1'b0) begin failures++; $display("FAIL split_x0_single got=%b exp=0", rd_wen1); end
        drive_a(1, 7, 1, 32'h77, 32'h88);
        tick;
        drive_a(0, 0, 0, 0, 0);
        checks++; if ({rd_wen1, rd_wide1, rd_addr1, rd_wdata1, err1} !== {2'b10, 5'd7, 32'h77, 1'b1}) begin failures++; $display("FAIL odd_split got=%b%b/%0d/%h/%b exp=10/7/77/1", rd_wen1, rd_wide1, rd_addr1, rd_wdata1, err1); end
        checks++; if ({rd_wen0, rd_wide0, rd_addr0, rd_wdata0, err0} !== {2'b10, 5'd7, 32'h77, 1'b1}) begin failures++; $display("FAIL odd_nosplit got=%b%b/%0d/%h/%b exp=10/7/77/1", rd_wen0, rd_wide0, rd_addr0, rd_wdata0, err0); end
        tick;
        checks++; if ({err0, err1, rd_wen1} !== 3'b000) begin failures++; $display("FAIL odd_pulse got=%b exp=000", {err0, err1, rd_wen1}); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        drive_b(1, 3, 0, 32'h3, 0);
        tick;
        drive_b(1, 4, 0, 32'h4, 0); drive_a(1, 6, 1, 32'h11, 32'h22);
        tick;
        drive_a(0, 0, 0, 0, 0); drive_b(0, 0, 0, 0, 0);
        checks++; if ({b_ready1, pend1} !== {1'b0, 32'h98}) begin failures++; $display("FAIL mid_setup got=%b/%h exp=0/98", b_ready1, pend1); end
        g_reset = 1'b1;
        tick;
        g_reset = 1'b0;
        checks++; if ({rd_wen1, b_ready1, pend1} !== {2'b01, 32'h0}) begin failures++; $display("FAIL mid_reset got=%b%b/%h exp=01/0", rd_wen1, b_ready1, pend1); end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if ({rd_wen0, rd_wen1} !== 2'b00) begin failures++; $display("FAIL mid_quiet%0d got=%b exp=00", i, {rd_wen0, rd_wen1}); end
        end
    endtask

    initial begin
        test_reset;
        test_single_a;
        test_priority;
        test_x0_and_b_latency;
        test_wide;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
